mult_share_ctrl: RTL and testbench
==================================

Name: mult_share_ctrl

Overview:
- Sequencer/arbiter sharing one sequential multi-cycle signed multiplier (start/done handshake, 8x8 -> 16-bit product) among N_REQ requesters.
- Sits between ALU-side requesters and the multiplier. Arbitrates round-robin, latches operands, pulses start and waits for done. Returns the product to the winner, with a watchdog on done.

Parameters:
- N_REQ, 4, number of requesters.
- WIDTH, 8, operand width; product is 2*WIDTH.
- TIMEOUT, 31, max cycles in WAIT before abort; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held with operands until gnt.
- a_in  in  N_REQ*WIDTH  packed multiplicands; slice i = a_in[i*WIDTH +: WIDTH].
- b_in  in  N_REQ*WIDTH  packed multipliers, same packing.
- gnt  out  N_REQ  one-hot, one-cycle pulse: operands of requester i accepted.
- res_valid  out  N_REQ  one-hot, one-cycle pulse: res_data belongs to requester i.
- res_data  out  2*WIDTH  product, or 0 on timeout.
- res_err  out  1  qualifies res_valid; 1 = timeout abort.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  WIDTH  multiplicand to the multiplier, held stable from LAUNCH through RESP.
- mul_b  out  WIDTH  multiplier operand, same hold rule.
- mul_product  in  2*WIDTH  multiplier result; valid when mul_done rises.
- mul_done  in  1  multiplier done level.

Behaviour:
- Reset (async): state=IDLE; rr_ptr=0; all outputs 0; done_q=0; timeout counter=0.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req, pick a winner by round-robin: the first set bit scanning upward from rr_ptr, wrapping.
  - Latch idx, mul_a=a_in[idx] and mul_b=b_in[idx]; move to LAUNCH.
  - If no req, stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - mul_start=1 and gnt[idx]=1; clear the timeout counter; move to WAIT.
  - The requester may drop req or change operands from the next cycle.
- WAIT:
  - Completion = mul_done & ~done_q, a rising edge; done_q is mul_done registered every cycle.
  - A level-high done left over from the previous op is not a completion.
  - On completion, capture mul_product into res_data, clear res_err, move to RESP.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT with no completion: res_data=0, res_err=1, move to RESP.
- RESP (exactly 1 cycle):
  - res_valid[idx]=1; rr_ptr=(idx+1) mod N_REQ; move to IDLE.
  - res_data and res_err hold until the next RESP.
- Output timing: gnt, res_valid and mul_start are registered outputs, asserted only in the named state.
- Latency:
  - req seen at edge k gives gnt/mul_start during cycle k+1.
  - res_valid comes 1 cycle after the done rising edge is sampled.
  - Minimum of 3 idle-to-idle cycles plus the multiplier latency.
- Simultaneous requests: only one grant per transaction. The others keep req high and wait; none are lost.
- A req deasserted before gnt is simply not served; there is no error.
- mul_done rising in the same cycle as mul_start, i.e. during LAUNCH, is ignored; done_q still updates.
- Back-to-back: a new arbitration may happen in the IDLE cycle immediately after RESP.
- Reset mid-operation: immediate return to IDLE and all outputs 0. No res_valid is issued for the aborted op. The multiplier shares rst.
- Arithmetic: the controller does not alter data. Products are two's-complement and passed through bit-exact.

Decomposition:
- Package mult_share_pkg:
  - state enum (IDLE, LAUNCH, WAIT, RESP);
  - default WIDTH and N_REQ;
  - counter width localparam = clog2(TIMEOUT+1).
- Sub-module rr_arbiter:
  - parameter N; inputs req[N] and ptr; outputs a one-hot grant and its index.
  - Purely combinational, used in IDLE.

Test Plan:
- Single requester: req[0], a=5, b=3, real multiplier -> gnt[0] one cycle, res_valid[0] with res_data=15, res_err=0.
- All four request simultaneously with operands (-4,6), (-3,-7), (127,1), (-128,-128):
  - grants in order 0,1,2,3;
  - results -24, 21, 127, 16384 (0x4000), each on its own res_valid bit.
- Fairness: after serving 3, re-raise req[2] and req[0] together -> rr_ptr=0, so 0 is granted first, then 2.
- Timeout: stub multiplier with mul_done held 0 -> res_valid after TIMEOUT(31) WAIT cycles with res_err=1 and res_data=0; the next request proceeds normally.
- Stale done: stub holds mul_done=1 from the prior op into LAUNCH, drops it, then raises it again 5 cycles later -> exactly one completion, from the second edge.
- Reset asserted during WAIT -> all outputs 0 immediately, busy=0, no res_valid. After release, req[1] (-50*50) -> res_data=-2500 (0xF63C).

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and sizing helpers for the multiplier-sharing controller.
// The counter width follows from the timeout so it can hold the value TIMEOUT.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 31;
    localparam int CNT_W       = $clog2(DEF_TIMEOUT + 1);

    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set request scanning upward from ptr,
// wrapping at N. Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int N = DEF_N_REQ,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int unsigned   j;
    logic [IW-1:0] jj;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        jj        = '0;
        for (int k = 0; k < N; k++) begin
            j  = (int'(ptr) + k) % N;
            jj = IW'(j);
            if (!any && req[jj]) begin
                any       = 1'b1;
                grant[jj] = 1'b1;
                grant_idx = jj;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin sequencer sharing one start/done multi-cycle multiplier among
// N_REQ requesters, with a watchdog that aborts a missing done.
//
// state  | meaning
// IDLE   | arbitrate; latch winner index and operands
// LAUNCH | one cycle: mul_start and gnt pulse, watchdog cleared
// WAIT   | wait for a rising edge on mul_done or the watchdog limit
// RESP   | one cycle: res_valid pulse, advance round-robin pointer
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_in,
    input  logic [N_REQ*WIDTH-1:0]   b_in,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         res_valid,
    output logic [2*WIDTH-1:0]       res_data,
    output logic                     res_err,
    output logic                     busy,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic                     mul_done
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT);

    state_t               state, state_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic [IW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [CW-1:0]        cnt, cnt_nxt, cnt_inc;
    logic                 done_q;
    logic [WIDTH-1:0]     mul_a_nxt, mul_b_nxt;
    logic [2*WIDTH-1:0]   res_data_nxt;
    logic                 res_err_nxt;
    logic [N_REQ-1:0]     gnt_nxt, res_valid_nxt, idx_onehot;
    logic                 mul_start_nxt;

    logic [N_REQ-1:0]     arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign busy       = (state != IDLE);
    assign idx_onehot = N_REQ'(1) << idx;
    assign cnt_inc    = cnt + 1'b1;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        rr_ptr_nxt    = rr_ptr;
        cnt_nxt       = cnt;
        mul_a_nxt     = mul_a;
        mul_b_nxt     = mul_b;
        res_data_nxt  = res_data;
        res_err_nxt   = res_err;
        gnt_nxt       = '0;
        res_valid_nxt = '0;
        mul_start_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    idx_nxt       = arb_idx;
                    mul_a_nxt     = a_in[arb_idx*WIDTH +: WIDTH];
                    mul_b_nxt     = b_in[arb_idx*WIDTH +: WIDTH];
                    gnt_nxt       = arb_grant;
                    mul_start_nxt = 1'b1;
                    state_nxt     = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A done level still high from the previous op is not a completion.
                if (mul_done && !done_q) begin
                    res_data_nxt  = mul_product;
                    res_err_nxt   = 1'b0;
                    res_valid_nxt = idx_onehot;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TC) begin
                        res_data_nxt  = '0;
                        res_err_nxt   = 1'b1;
                        res_valid_nxt = idx_onehot;
                        state_nxt     = RESP;
                    end
                end
            end
            RESP: begin
                rr_ptr_nxt = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            gnt       <= '0;
            res_valid <= '0;
            mul_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            rr_ptr    <= rr_ptr_nxt;
            cnt       <= cnt_nxt;
            done_q    <= mul_done;
            mul_a     <= mul_a_nxt;
            mul_b     <= mul_b_nxt;
            res_data  <= res_data_nxt;
            res_err   <= res_err_nxt;
            gnt       <= gnt_nxt;
            res_valid <= res_valid_nxt;
            mul_start <= mul_start_nxt;
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: behavioural multiplier stub, auto-releasing
// requesters and a round-robin/product reference model.
module tb_mult_share_ctrl;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 31;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  a_in, b_in;
    logic [N-1:0]    gnt, res_valid;
    logic [2*W-1:0]  res_data;
    logic            res_err, busy, mul_start;
    logic [W-1:0]    mul_a, mul_b;
    logic [2*W-1:0]  mul_product;
    logic            mul_done;

    mult_share_ctrl #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_done(mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int           idx;
        logic [15:0]  data;
        logic         err;
        logic [7:0]   ma;
        logic [7:0]   mb;
        int           t;
    } res_t;

    res_t rq[$];
    int   gq_idx[$];
    int   gq_t[$];

    // stub controls: mode 0 = working multiplier, 1 = done never rises
    int mode = 0, lat_fixed = 3, lat_rand = 0, stale_hold = 0;
    int m_ptr = 0;

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    function automatic int rr_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    initial begin : mul_model
        logic st;
        logic [7:0] sa, sb;
        logic [15:0] prod;
        int hold, cnt;
        bit active;
        hold = 0; cnt = 0; active = 0; prod = '0;
        forever begin
            @(negedge clk);
            st = mul_start; sa = mul_a; sb = mul_b;
            @(posedge clk);
            #1;
            if (rst) begin
                mul_done = 1'b0; active = 0; hold = 0; cnt = 0;
            end else if (st === 1'b1) begin
                hold   = stale_hold;
                cnt    = lat_rand ? $urandom_range(1, 8) : lat_fixed;
                active = (mode != 1);
                prod   = smul(sa, sb);
                if (hold == 0) mul_done = 1'b0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) mul_done = 1'b0;
            end else if (active) begin
                if (cnt <= 1) begin
                    mul_done = 1'b1; mul_product = prod; active = 0;
                end else cnt--;
            end
        end
    end

    initial begin : requesters
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (gnt[i] === 1'b1) begin
                    req[i] = 1'b0;
                    a_in[i*W +: W] = 8'($urandom);
                    b_in[i*W +: W] = 8'($urandom);
                end
            end
        end
    end

    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (gnt !== '0 || mul_start !== 1'b0) begin
                n_checks++;
                if (!$onehot(gnt) || mul_start !== 1'b1 || busy !== 1'b1)
                    $display("FAIL gnt_pulse gnt=%b mul_start=%b busy=%b, required one-hot gnt, mul_start=1, busy=1",
                             gnt, mul_start, busy);
                else n_pass++;
                for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) begin
                    gq_idx.push_back(i); gq_t.push_back(cyc);
                end
            end
            if (res_valid !== '0) begin
                n_checks++;
                if (!$onehot(res_valid))
                    $display("FAIL res_valid_onehot res_valid=%b, required one-hot", res_valid);
                else n_pass++;
                for (int i = 0; i < N; i++) if (res_valid[i] === 1'b1) begin
                    r.idx = i; r.data = res_data; r.err = res_err;
                    r.ma = mul_a; r.mb = mul_b; r.t = cyc;
                    rq.push_back(r);
                end
            end
        end
    end

    task automatic raise(input int i, input logic [7:0] a, input logic [7:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
        req[i] = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        rq.delete(); gq_idx.delete(); gq_t.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt, res_valid, res_data, res_err, busy, mul_start, mul_a, mul_b} !== '0)
            $display("FAIL reset_outputs gnt=%b rv=%b data=%h err=%b busy=%b start=%b a=%h b=%h, required all 0",
                     gnt, res_valid, res_data, res_err, busy, mul_start, mul_a, mul_b);
        else n_pass++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({gnt, res_valid, busy, mul_start} !== '0 || rq.size() != 0)
            $display("FAIL idle_no_req gnt=%b rv=%b busy=%b start=%b results=%0d, required all 0",
                     gnt, res_valid, busy, mul_start, rq.size());
        else n_pass++;
    endtask

    task automatic test_single();
        int t0;
        res_t r;
        apply_reset();
        mode = 0; lat_rand = 0; lat_fixed = 3; stale_hold = 0;
        @(negedge clk);
        t0 = cyc;
        raise(0, 8'd5, 8'd3);
        for (int k = 0; k < 100 && rq.size() < 1; k++) @(posedge clk);
        n_checks++;
        if (rq.size() < 1) begin
            $display("FAIL single_timeout results=%0d, required 1", rq.size());
            return;
        end else n_pass++;
        r = rq.pop_front();
        n_checks++;
        if (gq_idx.size() != 1 || gq_idx[0] != 0 || gq_t[0] != t0 + 1)
            $display("FAIL single_gnt grants=%0d idx=%0d cycle=%0d, required 1 grant idx 0 cycle %0d",
                     gq_idx.size(), gq_idx.size() ? gq_idx[0] : -1, gq_t.size() ? gq_t[0] : -1, t0 + 1);
        else n_pass++;
        n_checks++;
        if (r.idx != 0 || r.data !== 16'd15 || r.err !== 1'b0)
            $display("FAIL single_result idx=%0d data=%h err=%b, required idx 0 data 000f err 0", r.idx, r.data, r.err);
        else n_pass++;
        n_checks++;
        if (r.t != t0 + 1 + 2 + 3)
            $display("FAIL single_latency res_valid cycle=%0d, required %0d", r.t, t0 + 6);
        else n_pass++;
        m_ptr = 1;
    endtask

    task automatic test_all_four();
        logic [7:0]  ea[4] = '{8'hFC, 8'hFD, 8'h7F, 8'h80};
        logic [7:0]  eb[4] = '{8'h06, 8'hF9, 8'h01, 8'h80};
        logic [15:0] ep[4] = '{16'hFFE8, 16'h0015, 16'h007F, 16'h4000};
        res_t r;
        apply_reset();
        lat_rand = 1;
        @(negedge clk);
        for (int i = 0; i < N; i++) raise(i, ea[i], eb[i]);
        for (int k = 0; k < 400 && rq.size() < 4; k++) @(posedge clk);
        n_checks++;
        if (rq.size() < 4) begin
            $display("FAIL all4_timeout results=%0d, required 4", rq.size());
            return;
        end else n_pass++;
        for (int k = 0; k < 4; k++) begin
            r = rq.pop_front();
            n_checks++;
            if (r.idx != k || gq_idx[k] != k || r.data !== ep[k] || r.err !== 1'b0 ||
                r.ma !== ea[k] || r.mb !== eb[k])
                $display("FAIL all4_result_%0d idx=%0d gnt_idx=%0d data=%h err=%b a=%h b=%h, required idx %0d data %h err 0 a=%h b=%h",
                         k, r.idx, gq_idx[k], r.data, r.err, r.ma, r.mb, k, ep[k], ea[k], eb[k]);
            else n_pass++;
        end
        m_ptr = 0;
    endtask

    task automatic test_fairness();
        logic [7:0] ea[4], eb[4];
        int exp_order[2] = '{0, 2};
        res_t r;
        rq.delete(); gq_idx.delete(); gq_t.delete();
        @(negedge clk);
        for (int i = 0; i < N; i += 2) begin
            ea[i] = 8'($urandom); eb[i] = 8'($urandom);
            raise(i, ea[i], eb[i]);
        end
        for (int k = 0; k < 200 && rq.size() < 2; k++) @(posedge clk);
        n_checks++;
        if (rq.size() < 2) begin
            $display("FAIL fair_timeout results=%0d, required 2", rq.size());
            return;
        end else n_pass++;
        for (int k = 0; k < 2; k++) begin
            r = rq.pop_front();
            n_checks++;
            if (r.idx != exp_order[k] || r.data !== smul(ea[exp_order[k]], eb[exp_order[k]]) || r.err !== 1'b0)
                $display("FAIL fair_result_%0d idx=%0d data=%h err=%b, required idx %0d data %h err 0",
                         k, r.idx, r.data, r.err, exp_order[k], smul(ea[exp_order[k]], eb[exp_order[k]]));
            else n_pass++;
        end
        m_ptr = 3;
    endtask

    task automatic test_random();
        logic [3:0] mask, m;
        logic [7:0] ea[4], eb[4];
        res_t eq[$];
        res_t r, e;
        lat_rand = 1;
        for (int round = 0; round < 8; round++) begin
            rq.delete(); gq_idx.delete(); gq_t.delete(); eq.delete();
            @(negedge clk);
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) if (mask[i]) begin
                ea[i] = 8'($urandom); eb[i] = 8'($urandom);
                raise(i, ea[i], eb[i]);
            end
            m = mask;
            while (m != 0) begin
                e.idx = rr_pick(m, m_ptr);
                e.data = smul(ea[e.idx], eb[e.idx]); e.err = 1'b0;
                e.ma = ea[e.idx]; e.mb = eb[e.idx]; e.t = 0;
                eq.push_back(e);
                m[e.idx] = 1'b0;
                m_ptr = (e.idx + 1) % N;
            end
            for (int k = 0; k < 400 && rq.size() < eq.size(); k++) @(posedge clk);
            n_checks++;
            if (rq.size() < eq.size()) begin
                $display("FAIL rand_timeout round=%0d results=%0d, required %0d", round, rq.size(), eq.size());
                return;
            end else n_pass++;
            while (eq.size() > 0) begin
                r = rq.pop_front(); e = eq.pop_front();
                n_checks++;
                if (r.idx != e.idx || r.data !== e.data || r.err !== 1'b0 || r.ma !== e.ma || r.mb !== e.mb)
                    $display("FAIL rand_result round=%0d idx=%0d data=%h err=%b a=%h b=%h, required idx %0d data %h err 0 a=%h b=%h",
                             round, r.idx, r.data, r.err, r.ma, r.mb, e.idx, e.data, e.ma, e.mb);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        int   t0;
        res_t r;
        logic [7:0] a, b;
        rq.delete(); gq_idx.delete(); gq_t.delete();
        mode = 1; lat_rand = 0;
        @(negedge clk);
        t0 = cyc;
        raise(3, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 100 && rq.size() < 1; k++) @(posedge clk);
        n_checks++;
        if (rq.size() < 1) begin
            $display("FAIL timeout_no_resp results=0, required 1");
            return;
        end else n_pass++;
        r = rq.pop_front();
        n_checks++;
        if (r.idx != 3 || r.data !== 16'h0000 || r.err !== 1'b1 || r.t != t0 + 1 + 1 + TO)
            $display("FAIL timeout_result idx=%0d data=%h err=%b cycle=%0d, required idx 3 data 0000 err 1 cycle %0d",
                     r.idx, r.data, r.err, r.t, t0 + 2 + TO);
        else n_pass++;
        mode = 0; lat_fixed = 2;
        a = 8'($urandom); b = 8'($urandom);
        @(negedge clk);
        raise(1, a, b);
        for (int k = 0; k < 100 && rq.size() < 1; k++) @(posedge clk);
        n_checks++;
        if (rq.size() < 1) begin
            $display("FAIL timeout_recover no result, required 1");
            return;
        end
        r = rq.pop_front();
        if (r.idx != 1 || r.data !== smul(a, b) || r.err !== 1'b0)
            $display("FAIL timeout_recover idx=%0d data=%h err=%b, required idx 1 data %h err 0", r.idx, r.data, r.err, smul(a, b));
        else n_pass++;
        m_ptr = 2;
    endtask

    task automatic test_stale_done();
        int   t0;
        res_t r;
        rq.delete(); gq_idx.delete(); gq_t.delete();
        mode = 0; lat_rand = 0; lat_fixed = 5; stale_hold = 3;
        @(negedge clk);
        t0 = cyc;
        raise(2, 8'd9, 8'hF5);
        for (int k = 0; k < 60; k++) @(posedge clk);
        n_checks++;
        if (rq.size() != 1)
            $display("FAIL stale_count results=%0d, required 1", rq.size());
        else n_pass++;
        if (rq.size() > 0) begin
            r = rq.pop_front();
            n_checks++;
            if (r.idx != 2 || r.data !== 16'hFF9D || r.err !== 1'b0 || r.t != t0 + 1 + 2 + 3 + 5)
                $display("FAIL stale_result idx=%0d data=%h err=%b cycle=%0d, required idx 2 data ff9d err 0 cycle %0d",
                         r.idx, r.data, r.err, r.t, t0 + 11);
            else n_pass++;
        end
        stale_hold = 0;
        m_ptr = 3;
    endtask

    task automatic test_reset_mid();
        res_t r;
        rq.delete(); gq_idx.delete(); gq_t.delete();
        mode = 1;
        @(negedge clk);
        raise(2, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 20 && gq_idx.size() < 1; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({gnt, res_valid, res_data, res_err, busy, mul_start, mul_a, mul_b} !== '0 || gq_idx.size() != 1)
            $display("FAIL midreset_outputs grants=%0d gnt=%b rv=%b data=%h err=%b busy=%b start=%b a=%h b=%h, required 1 grant and all 0",
                     gq_idx.size(), gnt, res_valid, res_data, res_err, busy, mul_start, mul_a, mul_b);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0; mode = 0; lat_fixed = 3; m_ptr = 0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (rq.size() != 0 || busy !== 1'b0)
            $display("FAIL midreset_no_resp results=%0d busy=%b, required 0 and 0", rq.size(), busy);
        else n_pass++;
        raise(1, 8'hCE, 8'h32);
        for (int k = 0; k < 100 && rq.size() < 1; k++) @(posedge clk);
        n_checks++;
        if (rq.size() < 1) begin
            $display("FAIL midreset_recover no result, required 1");
            return;
        end
        r = rq.pop_front();
        if (r.idx != 1 || r.data !== 16'hF63C || r.err !== 1'b0)
            $display("FAIL midreset_recover idx=%0d data=%h err=%b, required idx 1 data f63c err 0", r.idx, r.data, r.err);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        mul_done = 1'b0; mul_product = '0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_random();
        test_timeout();
        test_stale_done();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_watchdog simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

endmodule
